// File: rtl/sobel_pkg.sv
// Shared types for the Sobel direction arbiter: quantizer angle ranges and the
// {id, range} result word held in the result FIFO.
package sobel_pkg;

  typedef enum logic [1:0] {
    DIR_H   = 2'b00,
    DIR_45  = 2'b01,
    DIR_V   = 2'b10,
    DIR_135 = 2'b11
  } dir_e;

  // Wide enough for the largest supported requester count (8).
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    dir_e                range;
  } res_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last accepted one,
// only while enabled; the pointer moves on every issued grant.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_valid
);

  logic [IDW-1:0] last_q, last_d;

  always_comb begin
    int idx;
    idx       = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    last_d    = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (en && !gnt_valid && req[IDW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
    // A grant is only offered to a valid requester, so grant == accept.
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
      last_d       = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sobel_dir_arbiter.sv
// Shares one fixed-latency gradient-direction quantizer among NREQ Sobel lanes,
// returning {id, range} results in issue order through a FWFT result FIFO.
module sobel_dir_arbiter
  import sobel_pkg::*;
#(
  parameter int NBIT_SOBEL = 11,
  parameter int NREQ       = 2,
  parameter int LAT        = 1,
  parameter int DEPTH      = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NREQ-1:0]            i_req_valid,
  output logic [NREQ-1:0]            o_req_ready,
  input  logic [NREQ*NBIT_SOBEL-1:0] i_req_gx,
  input  logic [NREQ*NBIT_SOBEL-1:0] i_req_gy,
  output logic                       o_dir_valid,
  output logic [NBIT_SOBEL-1:0]      o_dir_gx,
  output logic [NBIT_SOBEL-1:0]      o_dir_gy,
  input  logic [1:0]                 i_dir_range,
  output logic                       o_res_valid,
  input  logic                       i_res_ready,
  output logic [$clog2(NREQ)-1:0]    o_res_id,
  output logic [1:0]                 o_res_range,
  output logic                       o_busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, ready may depend on valid.

  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_valid;
  logic                  issue_ok;
  logic [CW:0]           occupancy;

  logic                  dir_valid_q, dir_valid_d;
  logic [NBIT_SOBEL-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [IDW-1:0]        dir_id_q, dir_id_d;
  logic [LAT-1:0]        tag_v_q, tag_v_d;
  logic [IDW-1:0]        tag_id_q [LAT];
  logic [IDW-1:0]        tag_id_d [LAT];
  res_t                  mem_q [DEPTH];
  res_t                  mem_d [DEPTH];
  res_t                  head;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;

  // Everything issued but not yet popped holds a credit; same-cycle pops are
  // not credited back, which keeps the check purely registered.
  always_comb begin
    occupancy = (CW+1)'(count_q) + (CW+1)'(dir_valid_q);
    for (int s = 0; s < LAT; s++) occupancy = occupancy + (CW+1)'(tag_v_q[s]);
    issue_ok = occupancy < (CW+1)'(DEPTH);
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .req      (i_req_valid),
    .en       (issue_ok),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always_comb begin
    dir_valid_d = gnt_valid;
    gx_d        = gx_q;
    gy_d        = gy_q;
    dir_id_d    = dir_id_q;
    if (gnt_valid) dir_id_d = gnt_idx;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gx_d = i_req_gx[i*NBIT_SOBEL +: NBIT_SOBEL];
        gy_d = i_req_gy[i*NBIT_SOBEL +: NBIT_SOBEL];
      end
    end

    tag_v_d[0]  = dir_valid_q;
    tag_id_d[0] = dir_id_q;
    for (int s = 1; s < LAT; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end

    // The quantizer result lines up with the last tag stage.
    push  = tag_v_q[LAT-1];
    pop   = (count_q != '0) && i_res_ready;
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q].id    = MAX_ID_W'(tag_id_q[LAT-1]);
      mem_d[wr_ptr_q].range = dir_e'(i_dir_range);
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dir_valid_q <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      dir_id_q    <= '0;
      tag_v_q     <= '0;
      for (int s = 0; s < LAT; s++) tag_id_q[s] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      dir_valid_q <= dir_valid_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      dir_id_q    <= dir_id_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) assert (!(push && count_q == CW'(DEPTH)));
  end

  assign head        = mem_q[rd_ptr_q];
  assign o_req_ready = gnt;
  assign o_dir_valid = dir_valid_q;
  assign o_dir_gx    = gx_q;
  assign o_dir_gy    = gy_q;
  assign o_res_valid = count_q != '0;
  assign o_res_id    = o_res_valid ? IDW'(head.id) : '0;
  assign o_res_range = o_res_valid ? head.range : DIR_H;
  assign o_busy      = o_res_valid | dir_valid_q | (|tag_v_q);

endmodule

// File: tb/tb_sobel_dir_arbiter.sv
// Randomized bench for sobel_dir_arbiter: an external quantizer model drives
// i_dir_range, and a cycle-level credit/round-robin model predicts every output.
module tb_sobel_dir_arbiter;

  localparam int NB    = 11;
  localparam int NREQ  = 2;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;
  localparam int IDW   = $clog2(NREQ);

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ-1:0]      o_req_ready;
  logic [NREQ*NB-1:0]   i_req_gx, i_req_gy;
  logic                 o_dir_valid;
  logic [NB-1:0]        o_dir_gx, o_dir_gy;
  logic [1:0]           i_dir_range;
  logic                 o_res_valid;
  logic                 i_res_ready;
  logic [IDW-1:0]       o_res_id;
  logic [1:0]           o_res_range;
  logic                 o_busy;

  // clock / reset
  always #5 i_clk = ~i_clk;

  sobel_dir_arbiter #(.NBIT_SOBEL(NB), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_gx   (i_req_gx),
    .i_req_gy   (i_req_gy),
    .o_dir_valid(o_dir_valid),
    .o_dir_gx   (o_dir_gx),
    .o_dir_gy   (o_dir_gy),
    .i_dir_range(i_dir_range),
    .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready),
    .o_res_id   (o_res_id),
    .o_res_range(o_res_range),
    .o_busy     (o_busy)
  );

  // Angle range from the gradient: |angle| below 22.5 deg is horizontal,
  // above 67.5 deg vertical, otherwise 45 (same signs) or 135 (opposite signs).
  function automatic logic [1:0] quant(logic [NB-1:0] gx, logic [NB-1:0] gy);
    int sx, sy, ax, ay;
    sx = $signed(gx);
    sy = $signed(gy);
    ax = (sx < 0) ? -sx : sx;
    ay = (sy < 0) ? -sy : sy;
    if (ay * 1000 <= ax * 414)  return 2'b00;
    if (ay * 1000 >= ax * 2414) return 2'b10;
    return ((sx > 0) == (sy > 0)) ? 2'b01 : 2'b11;
  endfunction

  // external quantizer with LAT cycles of latency
  logic [1:0] q_pipe [LAT];
  always @(posedge i_clk) begin
    q_pipe[0] <= quant(o_dir_gx, o_dir_gy);
    for (int k = 1; k < LAT; k++) q_pipe[k] <= q_pipe[k-1];
  end
  assign i_dir_range = q_pipe[LAT-1];

  // scoreboard: {ready_cycle[15:0], id[2:0], range[1:0]}
  logic [20:0]   exp_q[$];
  int            n_checks, n_errors, cyc, occ, last_m, hs_cnt;
  logic          m_dir_v;
  logic [NB-1:0] m_gx, m_gy;
  bit            granted [NREQ];
  bit            obs_hs  [NREQ];
  logic          v   [NREQ];
  logic [NB-1:0] sgx [NREQ];
  logic [NB-1:0] sgy [NREQ];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    occ     = 0;
    last_m  = NREQ - 1;
    m_dir_v = 1'b0;
    m_gx    = '0;
    m_gy    = '0;
    for (int i = 0; i < NREQ; i++) granted[i] = 1'b0;
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NREQ; i++) begin
      i_req_valid[i]       = v[i];
      i_req_gx[i*NB +: NB] = sgx[i];
      i_req_gy[i*NB +: NB] = sgy[i];
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_ready", 32'(o_req_ready), 32'(0));
    check_eq("rst_dir_valid", 32'(o_dir_valid), 32'(0));
    check_eq("rst_dir_gx",    32'(o_dir_gx),    32'(0));
    check_eq("rst_dir_gy",    32'(o_dir_gy),    32'(0));
    check_eq("rst_res_valid", 32'(o_res_valid), 32'(0));
    check_eq("rst_res_id",    32'(o_res_id),    32'(0));
    check_eq("rst_res_range", 32'(o_res_range), 32'(0));
    check_eq("rst_busy",      32'(o_busy),      32'(0));
  endtask

  // One clock cycle: apply inputs, check at the falling edge, advance the model.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    logic            exp_rv;
    int              g;
    apply_inputs();
    @(negedge i_clk);
    g = -1;
    if (occ < DEPTH)
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && v[(last_m + k) % NREQ]) g = (last_m + k) % NREQ;
    for (int i = 0; i < NREQ; i++) begin
      exp_rdy[i] = (i == g);
      obs_hs[i]  = i_req_valid[i] & o_req_ready[i];
      if (obs_hs[i]) hs_cnt++;
    end
    exp_rv = (exp_q.size() > 0) && (int'(exp_q[0][20:5]) <= cyc);
    check_eq("req_ready", 32'(o_req_ready), 32'(exp_rdy));
    check_eq("dir_valid", 32'(o_dir_valid), 32'(m_dir_v));
    check_eq("dir_gx",    32'(o_dir_gx),    32'(m_gx));
    check_eq("dir_gy",    32'(o_dir_gy),    32'(m_gy));
    check_eq("res_valid", 32'(o_res_valid), 32'(exp_rv));
    check_eq("busy",      32'(o_busy),      32'(occ > 0));
    if (exp_rv) begin
      check_eq("res_id",    32'(o_res_id),    32'(exp_q[0][4:2]));
      check_eq("res_range", 32'(o_res_range), 32'(exp_q[0][1:0]));
      if (i_res_ready) begin
        void'(exp_q.pop_front());
        occ--;
      end
    end
    m_dir_v = (g >= 0);
    for (int i = 0; i < NREQ; i++) granted[i] = (i == g);
    if (g >= 0) begin
      exp_q.push_back({16'(cyc + 2 + LAT), 3'(g), quant(sgx[g], sgy[g])});
      last_m = g;
      m_gx   = sgx[g];
      m_gy   = sgy[g];
      occ++;
    end
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  // driver: hold pending requests, renew data after a grant, maybe withdraw
  task automatic next_random(int p_valid, int p_drop);
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && !granted[i]) begin
        if ($urandom_range(0, 99) < p_drop) v[i] = 1'b0;
      end else begin
        v[i] = ($urandom_range(0, 99) < p_valid);
        if ($urandom_range(0, 1) == 0) begin
          sgx[i] = NB'($urandom_range(0, 2047));
          sgy[i] = NB'($urandom_range(0, 2047));
        end else begin
          sgx[i] = NB'(int'($urandom_range(0, 200)) - 100);
          sgy[i] = NB'(int'($urandom_range(0, 200)) - 100);
        end
      end
    end
  endtask

  task automatic issue_one(int r, int gx, int gy);
    bit done;
    done   = 1'b0;
    v[r]   = 1'b1;
    sgx[r] = NB'(gx);
    sgy[r] = NB'(gy);
    for (int n = 0; n < 20 && !done; n++) begin
      step();
      done = obs_hs[r];
    end
    check_eq("grant_wait", 32'(done), 32'(1));
    v[r] = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    i_res_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    cyc         = 0;
    hs_cnt      = 0;
    i_rst_n     = 1'b0;
    i_res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0; sgx[i] = '0; sgy[i] = '0;
    end
    reset_model();
    apply_inputs();
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs();
    i_rst_n = 1'b1;

    // single request, then the four canonical directions
    i_res_ready = 1'b1;
    issue_one(0, 100, 0);
    idle(5);
    issue_one(0, 0, 50);
    issue_one(1, 40, 40);
    issue_one(0, -40, 40);
    issue_one(1, -100, 5);
    idle(6);

    // both lanes always valid: alternating grants, one result per cycle
    repeat (16) begin next_random(100, 0); step(); end
    idle(6);

    // backpressure: exactly DEPTH issues, then drain and resume
    i_res_ready = 1'b0;
    hs_cnt = 0;
    repeat (10) begin next_random(100, 0); step(); end
    check_eq("bp_handshakes", 32'(hs_cnt), 32'(DEPTH));
    i_res_ready = 1'b1;
    repeat (10) begin next_random(100, 0); step(); end
    idle(8);

    // push and pop together while the FIFO holds DEPTH-1 entries
    i_res_ready = 1'b0;
    repeat (DEPTH - 1) issue_one(0, int'($urandom_range(0, 200)) - 100, int'($urandom_range(0, 200)) - 100);
    repeat (3) step();
    issue_one(0, 7, -90);
    step();
    i_res_ready = 1'b1;
    step();
    idle(8);

    // random traffic with random backpressure and withdrawn requests
    repeat (600) begin
      next_random(60, 10);
      i_res_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    idle(8);

    // reset with results buffered and one in flight
    i_res_ready = 1'b0;
    repeat (5) begin next_random(100, 0); step(); end
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    apply_inputs();
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs();
    reset_model();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    idle(6);

    repeat (400) begin
      next_random(70, 5);
      i_res_ready = ($urandom_range(0, 99) < 60);
      step();
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
